// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator (I/S/B/U/J/zimm) feeding a DEPTH-entry result FIFO.
// One-cycle push-to-head latency, no bypass; in_ready comes from count only, so a full FIFO refuses pushes even while popping.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int ERRW  = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [2:0]      imm_src,
   input  logic            zext,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm,
   output logic            imm_err,
   output logic [ERRW-1:0] err_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [XLEN-1:0] mem_imm [DEPTH];
   logic [DEPTH-1:0] mem_err;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;

   logic        push;
   logic        pop;
   logic        fill;
   logic        illegal;
   logic [63:0] ext64;
   logic        unused_bits;

   assign in_ready  = (count < FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign imm       = mem_imm[rd_ptr];
   assign imm_err   = mem_err[rd_ptr];

   assign fill    = ~zext & instr[31];
   assign illegal = imm_src[2] & imm_src[1];

   // Build every format at 64 bits and truncate, so XLEN=32 needs no zero-width replications.
   always_comb begin
      ext64 = '0;
      case (imm_src)
         3'b000:  ext64 = {{52{fill}}, instr[31:20]};
         3'b001:  ext64 = {{52{fill}}, instr[31:25], instr[11:7]};
         3'b010:  ext64 = {{51{fill}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         3'b011:  ext64 = {{32{instr[31]}}, instr[31:12], 12'b0};
         3'b100:  ext64 = {{43{fill}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         3'b101:  ext64 = {59'b0, instr[19:15]};
         default: ext64 = '0;
      endcase
   end

   assign unused_bits = ^{instr[6:0], ext64};

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         err_count <= '0;
         mem_err   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_imm[i] <= '0;
         end
      end else begin
         if (push) begin
            mem_imm[wr_ptr] <= ext64[XLEN-1:0];
            mem_err[wr_ptr] <= illegal;
            wr_ptr          <= wr_ptr + PW'(1);
            if (illegal && (err_count != '1)) begin
               err_count <= err_count + ERRW'(1);
            end
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: a 32-bit/ERRW=8 instance and a 64-bit/ERRW=2 instance share one stimulus stream.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] instr;
   logic [2:0]  imm_src;
   logic        zext;
   logic        out_ready;

   logic        in_ready_a, out_valid_a, imm_err_a;
   logic [31:0] imm_a;
   logic [7:0]  err_count_a;

   logic        in_ready_b, out_valid_b, imm_err_b;
   logic [63:0] imm_b;
   logic [1:0]  err_count_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .DEPTH(2), .ERRW(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
      .instr(instr), .imm_src(imm_src), .zext(zext),
      .out_valid(out_valid_a), .out_ready(out_ready), .imm(imm_a),
      .imm_err(imm_err_a), .err_count(err_count_a)
   );

   imm_gen_pipe #(.XLEN(64), .DEPTH(2), .ERRW(2)) dut64 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
      .instr(instr), .imm_src(imm_src), .zext(zext),
      .out_valid(out_valid_b), .out_ready(out_ready), .imm(imm_b),
      .imm_err(imm_err_b), .err_count(err_count_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] w, input logic [2:0] s, input logic z);
      in_valid = v;
      instr    = w;
      imm_src  = s;
      zext     = z;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 32'h0, 3'b000, 1'b0);
      out_ready = 1'b1;
      tick;
      tick;
      reset = 1'b0;
      chk("rst_out_valid", 64'(out_valid_a), 64'd0);
      chk("rst_imm", 64'(imm_a), 64'd0);
      chk("rst_imm_err", 64'(imm_err_a), 64'd0);
      chk("rst_err_count", 64'(err_count_a), 64'd0);
      chk("rst_in_ready", 64'(in_ready_a), 64'd1);

      // I-type sign and zero extension
      drive(1'b1, 32'hFFF00093, 3'b000, 1'b0);
      tick;
      chk("i_sext_valid", 64'(out_valid_a), 64'd1);
      chk("i_sext_imm", 64'(imm_a), 64'hFFFFFFFF);
      chk("i_sext_err", 64'(imm_err_a), 64'd0);
      chk("i_sext_imm64", imm_b, 64'hFFFFFFFFFFFFFFFF);
      drive(1'b1, 32'hFFF00093, 3'b000, 1'b1);
      tick;
      chk("i_zext_imm", 64'(imm_a), 64'h00000FFF);
      chk("i_zext_imm64", imm_b, 64'h0000000000000FFF);
      chk("pushpop_valid", 64'(out_valid_a), 64'd1);
      chk("pushpop_in_ready", 64'(in_ready_a), 64'd1);

      // B-type negative offset, J-type positive offset
      drive(1'b1, 32'hFE000EE3, 3'b010, 1'b0);
      tick;
      chk("b_imm", 64'(imm_a), 64'hFFFFFFFC);
      drive(1'b1, 32'h0080006F, 3'b100, 1'b0);
      tick;
      chk("j_imm", 64'(imm_a), 64'h00000008);

      // U-type at both widths, then zimm (always zero-extended)
      drive(1'b1, 32'h800002B7, 3'b011, 1'b1);
      tick;
      chk("u_imm32", 64'(imm_a), 64'h80000000);
      chk("u_imm64", imm_b, 64'hFFFFFFFF80000000);
      drive(1'b1, 32'h000FD073, 3'b101, 1'b0);
      tick;
      chk("zimm_imm32", 64'(imm_a), 64'h1F);
      chk("zimm_imm64", imm_b, 64'h1F);

      // Illegal formats
      drive(1'b1, 32'hFFFFFFFF, 3'b110, 1'b0);
      tick;
      chk("ill110_imm", 64'(imm_a), 64'd0);
      chk("ill110_err", 64'(imm_err_a), 64'd1);
      chk("ill110_cnt", 64'(err_count_a), 64'd1);
      drive(1'b1, 32'hFFFFFFFF, 3'b111, 1'b0);
      tick;
      chk("ill111_imm64", imm_b, 64'd0);
      chk("ill111_err", 64'(imm_err_a), 64'd1);
      chk("ill111_cnt", 64'(err_count_a), 64'd2);
      chk("ill111_cnt64", 64'(err_count_b), 64'd2);

      // Drain, then fill with out_ready low
      drive(1'b0, 32'h0, 3'b000, 1'b0);
      tick;
      chk("drain_valid", 64'(out_valid_a), 64'd0);
      out_ready = 1'b0;
      drive(1'b1, 32'hFFF00093, 3'b000, 1'b1);
      tick;
      chk("bp1_in_ready", 64'(in_ready_a), 64'd1);
      chk("bp1_head", 64'(imm_a), 64'h00000FFF);
      drive(1'b1, 32'hFE112E23, 3'b001, 1'b0);
      tick;
      chk("bp2_in_ready", 64'(in_ready_a), 64'd0);
      chk("bp2_head", 64'(imm_a), 64'h00000FFF);
      drive(1'b1, 32'h0080006F, 3'b100, 1'b0);
      tick;
      chk("bp3_held_in_ready", 64'(in_ready_a), 64'd0);
      chk("bp3_held_head", 64'(imm_a), 64'h00000FFF);
      // Pop while full: the waiting J word still cannot enter this cycle
      out_ready = 1'b1;
      tick;
      chk("pop1_head_s", 64'(imm_a), 64'hFFFFFFFC);
      chk("pop1_in_ready", 64'(in_ready_a), 64'd1);
      tick;
      chk("pushpop2_head_j", 64'(imm_a), 64'h00000008);
      chk("pushpop2_valid", 64'(out_valid_a), 64'd1);
      chk("pushpop2_in_ready", 64'(in_ready_a), 64'd1);

      // Three more illegal pushes: 2-bit counter saturates at 3
      drive(1'b1, 32'h0, 3'b110, 1'b0);
      tick;
      chk("sat3_cnt64", 64'(err_count_b), 64'd3);
      tick;
      chk("sat4_cnt64", 64'(err_count_b), 64'd3);
      drive(1'b1, 32'h0, 3'b111, 1'b0);
      tick;
      chk("sat5_cnt64", 64'(err_count_b), 64'd3);
      chk("sat5_cnt32", 64'(err_count_a), 64'd5);

      // Reset with two entries queued and a concurrent push and pop
      drive(1'b0, 32'h0, 3'b000, 1'b0);
      tick;
      out_ready = 1'b0;
      drive(1'b1, 32'hFFF00093, 3'b000, 1'b0);
      tick;
      drive(1'b1, 32'h800002B7, 3'b011, 1'b0);
      tick;
      chk("pre_rst_in_ready", 64'(in_ready_a), 64'd0);
      reset     = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 32'hFFF00093, 3'b110, 1'b0);
      tick;
      reset = 1'b0;
      drive(1'b0, 32'h0, 3'b000, 1'b0);
      chk("mid_rst_valid", 64'(out_valid_a), 64'd0);
      chk("mid_rst_imm", 64'(imm_a), 64'd0);
      chk("mid_rst_imm64", imm_b, 64'd0);
      chk("mid_rst_err", 64'(imm_err_a), 64'd0);
      chk("mid_rst_cnt", 64'(err_count_a), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready_a), 64'd1);
      tick;
      chk("post_rst_valid", 64'(out_valid_a), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
